addsub_share_ctrl: RTL and testbench

//  Arbitrates the shared 4-bit adder-subtractor between two requesters.

---
 rtl/addsub_share_ctrl_if.sv | 35 +++
 rtl/addsub_share_ctrl.sv | 131 +++++++++++++
 tb/tb_addsub_share_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_share_ctrl_if.sv
// Requester/datapath bundle around the shared adder-subtractor controller.
// Handshake: a requester raises Req_x and holds it (with Sub_x) until Done_x pulses for one cycle.
interface addsub_share_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             Req_0;
   logic             Req_1;
   logic             Sub_0;
   logic             Sub_1;
   logic [WIDTH-1:0] Sum;
   logic             Cout;
   logic             Ovf;
   logic             Select;
   logic             Sub;
   logic             Gnt_0;
   logic             Gnt_1;
   logic             Done_0;
   logic             Done_1;
   logic [WIDTH-1:0] Result;
   logic             Result_Cout;
   logic             Result_Ovf;
   logic             Busy;

   modport slave (
      input  Req_0, Req_1, Sub_0, Sub_1, Sum, Cout, Ovf,
      output Select, Sub, Gnt_0, Gnt_1, Done_0, Done_1,
             Result, Result_Cout, Result_Ovf, Busy
   );

   modport master (
      output Req_0, Req_1, Sub_0, Sub_1, Sum, Cout, Ovf,
      input  Select, Sub, Gnt_0, Gnt_1, Done_0, Done_1,
             Result, Result_Cout, Result_Ovf, Busy
   );
endinterface

// File: rtl/addsub_share_ctrl.sv
// Round-robin owner of the shared adder-subtractor: grants one requester, holds Select/Sub
// while the combinational datapath settles, then registers Sum/Cout/Ovf and pulses Done.
module addsub_share_ctrl #(
   parameter int WIDTH         = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic               Clk,
   input  logic               Reset,
   addsub_share_ctrl_if.slave bus,
   output logic [1:0]         o_dbg_state,
   output logic               o_dbg_last
);
   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t           r_state, w_state_n;
   logic             r_select, w_select_n;
   logic             r_sub, w_sub_n;
   logic             r_gnt0, w_gnt0_n;
   logic             r_gnt1, w_gnt1_n;
   logic             r_done0, w_done0_n;
   logic             r_done1, w_done1_n;
   logic             r_last, w_last_n;
   logic [CW-1:0]    r_cnt, w_cnt_n;
   logic [WIDTH-1:0] r_result, w_result_n;
   logic             r_cout, w_cout_n;
   logic             r_ovf, w_ovf_n;
   logic             w_winner;

   // On a tie the requester not served last time wins, so neither can starve.
   assign w_winner = (bus.Req_0 & bus.Req_1) ? ~r_last : bus.Req_1;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state  <= ST_IDLE;
         r_select <= 1'b0;
         r_sub    <= 1'b0;
         r_gnt0   <= 1'b0;
         r_gnt1   <= 1'b0;
         r_done0  <= 1'b0;
         r_done1  <= 1'b0;
         r_last   <= 1'b1;
         r_cnt    <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_select <= w_select_n;
         r_sub    <= w_sub_n;
         r_gnt0   <= w_gnt0_n;
         r_gnt1   <= w_gnt1_n;
         r_done0  <= w_done0_n;
         r_done1  <= w_done1_n;
         r_last   <= w_last_n;
         r_cnt    <= w_cnt_n;
         r_result <= w_result_n;
         r_cout   <= w_cout_n;
         r_ovf    <= w_ovf_n;
      end
   end

   always_comb begin
      w_state_n  = r_state;
      w_select_n = r_select;
      w_sub_n    = r_sub;
      w_gnt0_n   = r_gnt0;
      w_gnt1_n   = r_gnt1;
      w_done0_n  = 1'b0;
      w_done1_n  = 1'b0;
      w_last_n   = r_last;
      w_cnt_n    = r_cnt;
      w_result_n = r_result;
      w_cout_n   = r_cout;
      w_ovf_n    = r_ovf;
      case (r_state)
         ST_IDLE: begin
            if (bus.Req_0 | bus.Req_1) begin
               w_select_n = w_winner;
               w_sub_n    = w_winner ? bus.Sub_1 : bus.Sub_0;
               w_gnt0_n   = ~w_winner;
               w_gnt1_n   = w_winner;
               w_last_n   = w_winner;
               w_cnt_n    = CNT_LOAD;
               w_state_n  = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (r_cnt != '0) begin
               w_cnt_n = r_cnt - CW'(1);
            end else begin
               w_result_n = bus.Sum;
               w_cout_n   = bus.Cout;
               w_ovf_n    = bus.Ovf;
               w_done0_n  = r_gnt0;
               w_done1_n  = r_gnt1;
               w_state_n  = ST_DONE;
            end
         end
         ST_DONE: begin
            w_gnt0_n  = 1'b0;
            w_gnt1_n  = 1'b0;
            w_state_n = ST_IDLE;
         end
         default: begin
            w_gnt0_n  = 1'b0;
            w_gnt1_n  = 1'b0;
            w_state_n = ST_IDLE;
         end
      endcase
   end

   assign bus.Select      = r_select;
   assign bus.Sub         = r_sub;
   assign bus.Gnt_0       = r_gnt0;
   assign bus.Gnt_1       = r_gnt1;
   assign bus.Done_0      = r_done0;
   assign bus.Done_1      = r_done1;
   assign bus.Result      = r_result;
   assign bus.Result_Cout = r_cout;
   assign bus.Result_Ovf  = r_ovf;
   assign bus.Busy        = (r_state != ST_IDLE);
   assign o_dbg_state     = r_state;
   assign o_dbg_last      = r_last;
endmodule

// File: tb/tb_addsub_share_ctrl.sv
// Bench for addsub_share_ctrl: two controllers (settle 1 and 3) each driving a mux + adder-subtractor
// datapath, checked against an arithmetic reference and a round-robin owner model.
module tb_addsub_share_ctrl;
   localparam int W = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst  [2];
   logic         req0 [2];
   logic         req1 [2];
   logic         sub0 [2];
   logic         sub1 [2];
   logic [W-1:0] a0   [2];
   logic [W-1:0] b0   [2];
   logic [W-1:0] a1   [2];
   logic [W-1:0] b1   [2];
   logic [1:0]   dbg_state_a, dbg_state_b;
   logic         dbg_last_a, dbg_last_b;

   addsub_share_ctrl_if #(.WIDTH(W)) bus_a ();
   addsub_share_ctrl_if #(.WIDTH(W)) bus_b ();

   assign bus_a.Req_0 = req0[0];
   assign bus_a.Req_1 = req1[0];
   assign bus_a.Sub_0 = sub0[0];
   assign bus_a.Sub_1 = sub1[0];
   assign bus_b.Req_0 = req0[1];
   assign bus_b.Req_1 = req1[1];
   assign bus_b.Sub_0 = sub0[1];
   assign bus_b.Sub_1 = sub1[1];

   // Shared datapath: operand muxes followed by a ripple-style adder-subtractor.
   logic [W-1:0] opa_a, opb_a, opbx_a, opa_b, opb_b, opbx_b;
   logic [W:0]   tot_a, tot_b;
   assign opa_a  = bus_a.Select ? a1[0] : a0[0];
   assign opb_a  = bus_a.Select ? b1[0] : b0[0];
   assign opbx_a = opb_a ^ {W{bus_a.Sub}};
   assign tot_a  = {1'b0, opa_a} + {1'b0, opbx_a} + {{W{1'b0}}, bus_a.Sub};
   assign bus_a.Sum  = tot_a[W-1:0];
   assign bus_a.Cout = tot_a[W];
   assign bus_a.Ovf  = (opa_a[W-1] == opbx_a[W-1]) && (tot_a[W-1] != opa_a[W-1]);
   assign opa_b  = bus_b.Select ? a1[1] : a0[1];
   assign opb_b  = bus_b.Select ? b1[1] : b0[1];
   assign opbx_b = opb_b ^ {W{bus_b.Sub}};
   assign tot_b  = {1'b0, opa_b} + {1'b0, opbx_b} + {{W{1'b0}}, bus_b.Sub};
   assign bus_b.Sum  = tot_b[W-1:0];
   assign bus_b.Cout = tot_b[W];
   assign bus_b.Ovf  = (opa_b[W-1] == opbx_b[W-1]) && (tot_b[W-1] != opa_b[W-1]);

   addsub_share_ctrl #(.WIDTH(W), .SETTLE_CYCLES(1)) u_dut_s1 (
      .Clk(clk), .Reset(rst[0]), .bus(bus_a), .o_dbg_state(dbg_state_a), .o_dbg_last(dbg_last_a)
   );
   addsub_share_ctrl #(.WIDTH(W), .SETTLE_CYCLES(3)) u_dut_s3 (
      .Clk(clk), .Reset(rst[1]), .bus(bus_b), .o_dbg_state(dbg_state_b), .o_dbg_last(dbg_last_b)
   );

   typedef struct packed {
      logic         select, sub, gnt0, gnt1, done0, done1, busy, rcout, rovf, last;
      logic [1:0]   state;
      logic [W-1:0] result;
   } obs_t;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [5:0]   exp_q [$];
   bit           last_m [2];
   logic [5:0]   held_m [2];
   int           settle [2];

   function automatic obs_t sample(input int k);
      obs_t o;
      if (k == 0) begin
         o = '{bus_a.Select, bus_a.Sub, bus_a.Gnt_0, bus_a.Gnt_1, bus_a.Done_0, bus_a.Done_1,
               bus_a.Busy, bus_a.Result_Cout, bus_a.Result_Ovf, dbg_last_a, dbg_state_a, bus_a.Result};
      end else begin
         o = '{bus_b.Select, bus_b.Sub, bus_b.Gnt_0, bus_b.Gnt_1, bus_b.Done_0, bus_b.Done_1,
               bus_b.Busy, bus_b.Result_Cout, bus_b.Result_Ovf, dbg_last_b, dbg_state_b, bus_b.Result};
      end
      return o;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference arithmetic on plain integers: {cout, ovf, result}.
   function automatic logic [5:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      int ua, ub, sa, sb, r, sr;
      logic cout;
      ua = int'(a);
      ub = int'(b);
      sa = a[W-1] ? ua - 16 : ua;
      sb = b[W-1] ? ub - 16 : ub;
      if (!s) begin
         r = ua + ub;  sr = sa + sb;  cout = (r > 15);
      end else begin
         r = ua - ub;  sr = sa - sb;  cout = (ua >= ub);
      end
      return {cout, (sr > 7) || (sr < -8), 4'(r & 15)};
   endfunction

   task automatic check_reset_outputs(input int k, input string tag);
      obs_t o;
      o = sample(k);
      check({tag, "_flags"}, {o.select, o.sub, o.gnt0, o.gnt1, o.done0, o.done1, o.busy}, 8'h00);
      check({tag, "_result"}, {o.rcout, o.rovf, o.result}, 8'h00);
      check({tag, "_last"}, o.last, 8'h01);
      check({tag, "_state_idle"}, o.state, 8'h00);
   endtask

   // Entered at a negedge with requests applied and the controller idle; returns at the
   // negedge of the first idle cycle after Done.
   task automatic do_op(input int k, input bit mid, input logic [W-1:0] ma, input logic [W-1:0] mb,
                        output bit w);
      obs_t o;
      logic sw;
      logic [5:0] e;
      w = (req0[k] && req1[k]) ? ~last_m[k] : req1[k];
      last_m[k] = w;
      sw = w ? sub1[k] : sub0[k];
      @(posedge clk); @(negedge clk);
      o = sample(k);
      check("grant_gnt", {o.gnt1, o.gnt0}, w ? 8'h2 : 8'h1);
      check("grant_select", o.select, 8'(w));
      check("grant_sub", o.sub, 8'(sw));
      check("grant_busy", o.busy, 8'h1);
      check("grant_no_done", {o.done1, o.done0}, 8'h0);
      if (mid) begin
         if (w) begin a1[k] = ma; b1[k] = mb; sub1[k] = ~sub1[k]; end
         else   begin a0[k] = ma; b0[k] = mb; sub0[k] = ~sub0[k]; end
      end
      e = w ? ref_op(a1[k], b1[k], sw) : ref_op(a0[k], b0[k], sw);
      exp_q.push_back(e);
      for (int c = 1; c < settle[k]; c++) begin
         @(posedge clk); @(negedge clk);
         o = sample(k);
         check("settle_no_done", {o.done1, o.done0}, 8'h0);
         check("settle_hold", {o.select, o.sub, o.gnt1, o.gnt0}, {4'h0, w, sw, w, ~w});
      end
      @(posedge clk); @(negedge clk);
      o = sample(k);
      check("done_pulse", {o.done1, o.done0}, w ? 8'h2 : 8'h1);
      check("done_gnt", {o.gnt1, o.gnt0}, w ? 8'h2 : 8'h1);
      e = exp_q.pop_front();
      held_m[k] = e;
      check("result", o.result, 8'(e[3:0]));
      check("result_flags", {o.rcout, o.rovf}, 8'(e[5:4]));
      @(posedge clk); @(negedge clk);
      o = sample(k);
      check("idle_busy", o.busy, 8'h0);
      check("idle_clear", {o.gnt1, o.gnt0, o.done1, o.done0}, 8'h0);
      check("idle_hold", {o.rcout, o.rovf, o.result}, 8'(held_m[k]));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      obs_t o;
      bit   w;
      int   pat;
      settle[0] = 1;
      settle[1] = 3;
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; req0[k] = 1'b0; req1[k] = 1'b0; sub0[k] = 1'b0; sub1[k] = 1'b0;
         a0[k] = '0; b0[k] = '0; a1[k] = '0; b1[k] = '0;
         last_m[k] = 1'b1; held_m[k] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      repeat (10) @(negedge clk);
      check_reset_outputs(0, "reset_s1");
      check_reset_outputs(1, "reset_s3");

      // Requester 0 add: 5 + 3 = 8, signed overflow.
      req0[0] = 1'b1; a0[0] = 4'd5; b0[0] = 4'd3; sub0[0] = 1'b0;
      do_op(0, 1'b0, '0, '0, w);
      req0[0] = 1'b0;
      o = sample(0);
      check("ex_add_owner", 8'(w), 8'h0);
      check("ex_add_result", {o.rcout, o.rovf, o.result}, 8'b00_01_1000);

      // Requester 1 subtract: 2 - 7 = 11 (4-bit), no carry, no overflow.
      req1[0] = 1'b1; a1[0] = 4'd2; b1[0] = 4'd7; sub1[0] = 1'b1;
      do_op(0, 1'b0, '0, '0, w);
      req1[0] = 1'b0;
      o = sample(0);
      check("ex_sub_owner", 8'(w), 8'h1);
      check("ex_sub_result", {o.rcout, o.rovf, o.result}, 8'b00_00_1011);

      // Both requesting: ownership must alternate starting with requester 0.
      for (int i = 0; i < 4; i++) begin
         req0[0] = 1'b1; req1[0] = 1'b1;
         a0[0] = W'($urandom_range(0, 15)); b0[0] = W'($urandom_range(0, 15));
         a1[0] = W'($urandom_range(0, 15)); b1[0] = W'($urandom_range(0, 15));
         sub0[0] = 1'($urandom_range(0, 1)); sub1[0] = 1'($urandom_range(0, 1));
         do_op(0, 1'b0, '0, '0, w);
         check("tie_order", 8'(w), 8'(i % 2));
      end
      req0[0] = 1'b0; req1[0] = 1'b0;

      // Reset during SETTLE on the 3-cycle controller abandons the op.
      req0[1] = 1'b1; a0[1] = 4'd1; b0[1] = 4'd1; sub0[1] = 1'b0;
      @(posedge clk); @(negedge clk);
      o = sample(1);
      check("rst_mid_granted", {o.gnt1, o.gnt0, o.busy}, 8'b011);
      rst[1] = 1'b1; req0[1] = 1'b0;
      @(posedge clk); @(negedge clk);
      check_reset_outputs(1, "rst_mid");
      rst[1] = 1'b0;
      last_m[1] = 1'b1; held_m[1] = '0;
      repeat (4) begin
         @(posedge clk); @(negedge clk);
         o = sample(1);
         check("rst_mid_no_done", {o.done1, o.done0, o.busy}, 8'h0);
      end
      req0[1] = 1'b1; req1[1] = 1'b1;
      do_op(1, 1'b0, '0, '0, w);
      check("rst_mid_tie_owner", 8'(w), 8'h0);
      req0[1] = 1'b0; req1[1] = 1'b0;

      // Operands and mode changed mid-op: capture follows the operands, mode stays as granted.
      req0[1] = 1'b1; a0[1] = 4'd3; b0[1] = 4'd4; sub0[1] = 1'b0;
      do_op(1, 1'b1, 4'd9, 4'd6, w);
      req0[1] = 1'b0;
      o = sample(1);
      check("mid_change_result", {o.rcout, o.rovf, o.result}, 8'b00_00_1111);

      // Randomized request patterns and operands on both controllers.
      for (int k = 0; k < 2; k++) begin
         for (int n = 0; n < 16; n++) begin
            pat = int'($urandom_range(1, 3));
            req0[k] = pat[0]; req1[k] = pat[1];
            a0[k] = W'($urandom_range(0, 15)); b0[k] = W'($urandom_range(0, 15));
            a1[k] = W'($urandom_range(0, 15)); b1[k] = W'($urandom_range(0, 15));
            sub0[k] = 1'($urandom_range(0, 1)); sub1[k] = 1'($urandom_range(0, 1));
            do_op(k, (k == 1) && ($urandom_range(0, 1) == 1),
                  W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), w);
            if ($urandom_range(0, 2) == 0) begin
               req0[k] = 1'b0; req1[k] = 1'b0;
               @(posedge clk); @(negedge clk);
               o = sample(k);
               check("gap_idle", {o.busy, o.gnt1, o.gnt0, o.done1, o.done0}, 8'h0);
            end
         end
         req0[k] = 1'b0; req1[k] = 1'b0;
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
